// File: rtl/slave_bus_arbiter.sv
// Round-robin arbiter for the shared slave bus: grants one bus_interface at a time,
// drains its length-prefixed frame through sl_data_latch and forwards it upstream.
module slave_bus_arbiter #(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] sl_arb_request,
    output logic [NUM_PORTS-1:0] sl_arb_grant,
    input  logic [7:0]           sl_data,
    output logic                 sl_data_latch,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 out_data_valid,
    output logic                 out_frame_start,
    output logic                 out_frame_end,
    output logic [2:0]           out_port,
    output logic                 frame_abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_LEN,
        S_DATA,
        S_DONE
    } state_t;

    state_t               state, state_d;
    logic [NUM_PORTS-1:0] grant_d, grant_sel;
    logic [2:0]           ptr, ptr_d, port_d;
    logic [7:0]           cnt, cnt_d;
    logic [1:0]           settle, settle_d;
    logic [7:0]           data_d;
    logic                 valid_d, start_d, end_d, abort_d;
    logic [7:0]           req_ext;
    logic [2:0]           rr_cand, rr_idx;
    logic                 rr_found;
    logic                 req_held;

    // First requester at or after the pointer, wrapping at NUM_PORTS.
    always_comb begin
        req_ext                  = '0;
        req_ext[NUM_PORTS-1:0]   = sl_arb_request;
        rr_found                 = 1'b0;
        rr_idx                   = '0;
        rr_cand                  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            rr_cand = 3'((32'(ptr) + i) % NUM_PORTS);
            if (!rr_found && req_ext[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
        grant_sel = '0;
        for (int unsigned j = 0; j < NUM_PORTS; j++) begin
            grant_sel[j] = (3'(j) == rr_idx);
        end
    end

    assign req_held = |(sl_arb_request & sl_arb_grant);

    always_comb begin
        state_d       = state;
        grant_d       = sl_arb_grant;
        ptr_d         = ptr;
        port_d        = out_port;
        cnt_d         = cnt;
        settle_d      = settle;
        sl_data_latch = 1'b0;
        data_d        = out_data;
        valid_d       = 1'b0;
        start_d       = 1'b0;
        end_d         = 1'b0;
        abort_d       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (rr_found) begin
                    grant_d  = grant_sel;
                    port_d   = rr_idx;
                    settle_d = 2'(SETTLE_CYCLES);
                    state_d  = (SETTLE_CYCLES == 0) ? S_LEN : S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (!req_held) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    settle_d = settle - 2'd1;
                    if (settle == 2'd1) state_d = S_LEN;
                end
            end
            S_LEN, S_DATA: begin
                if (!req_held) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    sl_data_latch = out_ready;
                    if (out_ready) begin
                        data_d  = sl_data;
                        valid_d = 1'b1;
                        if (state == S_LEN) begin
                            start_d = 1'b1;
                            cnt_d   = sl_data;
                            if (sl_data == 8'd0) begin
                                end_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_DATA;
                            end
                        end else begin
                            cnt_d = cnt - 8'd1;
                            if (cnt == 8'd1) begin
                                end_d   = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                    end
                end
            end
            S_DONE: begin
                grant_d = '0;
                ptr_d   = (out_port == 3'(NUM_PORTS - 1)) ? 3'd0 : out_port + 3'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            sl_arb_grant    <= '0;
            ptr             <= '0;
            out_port        <= '0;
            cnt             <= '0;
            settle          <= '0;
            out_data        <= '0;
            out_data_valid  <= 1'b0;
            out_frame_start <= 1'b0;
            out_frame_end   <= 1'b0;
            frame_abort     <= 1'b0;
        end else begin
            state           <= state_d;
            sl_arb_grant    <= grant_d;
            ptr             <= ptr_d;
            out_port        <= port_d;
            cnt             <= cnt_d;
            settle          <= settle_d;
            out_data        <= data_d;
            out_data_valid  <= valid_d;
            out_frame_start <= start_d;
            out_frame_end   <= end_d;
            frame_abort     <= abort_d;
        end
    end

endmodule
